bin2bcd_seq: RTL and testbench

- Sequential double-dabble converter. Turns an unsigned binary value into packed BCD digits, one shift per clock.
- Sits directly upstream of the N x 7-segment driver.
- o_Data drives the driver's digit-data input; o_Idle drives its idle input, so the display never latches a half-converted value.
- Owns overflow detection for values that cannot be shown on DIGITS digits.

---
 rtl/bin2bcd_seq.sv | 119 +++++++++++
 tb/tb_bin2bcd_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter.
// One shift per clock; WIDTH shift cycles plus one result cycle.
// Feeds an N x 7-segment driver: o_Data is its digit data and o_Idle its
// idle input, so the display only ever sees complete results.
//
// Ports:
//   i_Clock     system clock, rising edge
//   i_Reset     asynchronous active-high reset
//   i_Start     conversion request, sampled only in IDLE
//   i_Value     unsigned binary input, captured with i_Start
//   o_Busy      high in SHIFT and DONE
//   o_Idle      ~o_Busy
//   o_Done      one-cycle pulse when o_Data/o_Overflow update
//   o_Data      packed BCD, digit 0 in [3:0], held between conversions
//   o_Overflow  last value did not fit in DIGITS digits
//
// state | meaning
// IDLE  | waiting for i_Start, outputs hold the last result
// SHIFT | one adjust-and-shift per edge, WIDTH edges
// DONE  | publish result, pulse o_Done, return to IDLE
module bin2bcd_seq #(
   parameter int       WIDTH    = 14,
   parameter int       DIGITS   = 4,
   parameter bit       SATURATE = 1'b1
) (
   input  logic                  i_Clock,
   input  logic                  i_Reset,
   input  logic                  i_Start,
   input  logic [WIDTH-1:0]      i_Value,
   output logic                  o_Busy,
   output logic                  o_Idle,
   output logic                  o_Done,
   output logic [DIGITS*4-1:0]   o_Data,
   output logic                  o_Overflow
);

   // Enough digits to hold 2^WIDTH-1 without internal overflow.
   localparam int MIN_DIGITS = (WIDTH + 2) / 3;
   localparam int INT_DIGITS = (DIGITS > MIN_DIGITS) ? DIGITS : MIN_DIGITS;
   localparam int ACC_W      = INT_DIGITS * 4;
   localparam int SR_W       = ACC_W + WIDTH;
   // Six bits so that WIDTH=32 can be loaded directly.
   localparam int CNT_W      = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t              r_state;
   logic [SR_W-1:0]     r_shift;
   logic [CNT_W-1:0]    r_cnt;

   logic [SR_W-1:0]     w_adj;
   logic [ACC_W-1:0]    w_acc;
   logic                w_ovf;

   // Add-3 on every BCD digit >= 5 before the shift; the binary field is
   // passed through untouched.
   always_comb begin
      w_adj = r_shift;
      for (int i = 0; i < INT_DIGITS; i++) begin
         if (r_shift[WIDTH + 4*i +: 4] >= 4'd5)
            w_adj[WIDTH + 4*i +: 4] = r_shift[WIDTH + 4*i +: 4] + 4'd3;
      end
   end

   assign w_acc = r_shift[SR_W-1 -: ACC_W];
   // Any nonzero digit above the displayed ones means the value is too big.
   assign w_ovf = |(w_acc >> (DIGITS*4));

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         r_state    <= IDLE;
         r_shift    <= '0;
         r_cnt      <= '0;
         o_Busy     <= 1'b0;
         o_Done     <= 1'b0;
         o_Data     <= '0;
         o_Overflow <= 1'b0;
      end else begin
         o_Done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_Start) begin
                  r_shift <= {{ACC_W{1'b0}}, i_Value};
                  r_cnt   <= CNT_W'(WIDTH);
                  o_Busy  <= 1'b1;
                  r_state <= SHIFT;
               end
            end
            SHIFT: begin
               r_shift <= {w_adj[SR_W-2:0], 1'b0};
               r_cnt   <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1))
                  r_state <= DONE;
            end
            DONE: begin
               o_Overflow <= w_ovf;
               if (w_ovf && SATURATE)
                  o_Data <= {DIGITS{4'h9}};
               else
                  o_Data <= w_acc[DIGITS*4-1:0];
               o_Done  <= 1'b1;
               o_Busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               o_Busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign o_Idle = ~o_Busy;

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [13:0]   value = '0;

   logic          busy, idle, done, ovf;
   logic [15:0]   data;
   logic          busy0, idle0, done0, ovf0;
   logic [15:0]   data0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   bin2bcd_seq #(.WIDTH(14), .DIGITS(4), .SATURATE(1'b1)) dut (
      .i_Clock(clk), .i_Reset(rst), .i_Start(start), .i_Value(value),
      .o_Busy(busy), .o_Idle(idle), .o_Done(done),
      .o_Data(data), .o_Overflow(ovf)
   );

   bin2bcd_seq #(.WIDTH(14), .DIGITS(4), .SATURATE(1'b0)) dut0 (
      .i_Clock(clk), .i_Reset(rst), .i_Start(start), .i_Value(value),
      .o_Busy(busy0), .o_Idle(idle0), .o_Done(done0),
      .o_Data(data0), .o_Overflow(ovf0)
   );

   typedef struct {
      int          v;
      logic [15:0] exp_sat;
      logic [15:0] exp_trunc;
      logic        exp_ovf;
   } vec_t;

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int          x;
      r = '0;
      x = v % 10000;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Pulse i_Start with v and wait for dut o_Done; returns at the negedge of
   // the o_Done cycle. lat = edges after the accept edge, -1 on timeout.
   task automatic run(input int v, output int lat, output int idle_bad);
      int k;
      @(negedge clk);
      start = 1'b1;
      value = 14'(v);
      @(negedge clk);
      start = 1'b0;
      k = 0;
      idle_bad = 0;
      while (!done && k < 40) begin
         if (idle !== 1'b0) idle_bad++;
         @(negedge clk);
         k++;
      end
      lat = done ? k : -1;
   endtask

   // Stability and single-pulse monitor on the saturating instance.
   logic [15:0] last_data = '0;
   logic        prev_done = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         last_data = data;
      end else if (done) begin
         n_tests++;
         if (prev_done) begin
            n_fail++;
            $display("FAIL done_pulse: o_Done high %0d cycles, expected 1", 2);
         end
         last_data = data;
      end else if (data !== last_data) begin
         n_tests++;
         n_fail++;
         $display("FAIL data_stable: got %h expected %h", data, last_data);
         last_data = data;
      end
      prev_done = done;
   end

   vec_t vecs[8];

   initial begin
      int lat, ib, pulses, k, v;

      vecs[0] = '{1234,  16'h1234, 16'h1234, 1'b0};
      vecs[1] = '{0,     16'h0000, 16'h0000, 1'b0};
      vecs[2] = '{9999,  16'h9999, 16'h9999, 1'b0};
      vecs[3] = '{10000, 16'h9999, 16'h0000, 1'b1};
      vecs[4] = '{16383, 16'h9999, 16'h6383, 1'b1};
      vecs[5] = '{5,     16'h0005, 16'h0005, 1'b0};
      vecs[6] = '{100,   16'h0100, 16'h0100, 1'b0};
      vecs[7] = '{4321,  16'h4321, 16'h4321, 1'b0};

      rst = 1'b1;
      #12;
      check("reset_data", 32'(data), 32'h0);
      check("reset_ovf",  32'(ovf), 32'h0);
      check("reset_done", 32'(done), 32'h0);
      check("reset_idle", 32'(idle), 32'h1);
      @(negedge clk); #1 rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         run(vecs[i].v, lat, ib);
         check($sformatf("lat_%0d", vecs[i].v), 32'(lat), 32'd15);
         check($sformatf("idle_low_%0d", vecs[i].v), 32'(ib), 32'd0);
         check($sformatf("data_sat_%0d", vecs[i].v), 32'(data), 32'(vecs[i].exp_sat));
         check($sformatf("ovf_sat_%0d", vecs[i].v), 32'(ovf), 32'(vecs[i].exp_ovf));
         check($sformatf("data_trunc_%0d", vecs[i].v), 32'(data0), 32'(vecs[i].exp_trunc));
         check($sformatf("ovf_trunc_%0d", vecs[i].v), 32'(ovf0), 32'(vecs[i].exp_ovf));
         @(negedge clk);
         check($sformatf("done_low_%0d", vecs[i].v), 32'(done), 32'd0);
      end

      // Start while busy is ignored.
      @(negedge clk);
      start = 1'b1; value = 14'd42;
      @(negedge clk);
      start = 1'b0;
      pulses = 0;
      for (int c = 0; c < 25; c++) begin
         if (c == 5) begin start = 1'b1; value = 14'd77; end
         else start = 1'b0;
         if (done) pulses++;
         @(negedge clk);
      end
      start = 1'b0;
      check("busy_start_pulses", 32'(pulses), 32'd1);
      check("busy_start_data", 32'(data), 32'h0042);

      // Start accepted in the o_Done cycle.
      run(300, lat, ib);
      check("b2b_first", 32'(data), 32'h0300);
      start = 1'b1; value = 14'd77;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!done && k < 40) begin @(negedge clk); k++; end
      check("b2b_lat", 32'(k), 32'd15);
      check("b2b_data", 32'(data), 32'h0077);

      // Asynchronous reset mid-conversion.
      @(negedge clk);
      start = 1'b1; value = 14'd1234;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check("arst_data", 32'(data), 32'h0);
      check("arst_busy", 32'(busy), 32'h0);
      check("arst_idle", 32'(idle), 32'h1);
      check("arst_done", 32'(done), 32'h0);
      @(negedge clk); #1 rst = 1'b0;
      pulses = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      check("arst_no_done", 32'(pulses), 32'd0);
      run(555, lat, ib);
      check("after_rst_data", 32'(data), 32'h0555);
      check("after_rst_lat", 32'(lat), 32'd15);

      // Random sweep against the decimal model.
      for (int i = 0; i < 1000; i++) begin
         v = (i % 4 == 0) ? int'($urandom_range(9990, 16383)) : int'($urandom_range(0, 16383));
         run(v, lat, ib);
         if (lat != 15) check($sformatf("rnd_lat_%0d", v), 32'(lat), 32'd15);
         check($sformatf("rnd_sat_%0d", v), 32'(data),
               32'((v >= 10000) ? 16'h9999 : to_bcd(v)));
         check($sformatf("rnd_trunc_%0d", v), 32'(data0), 32'(to_bcd(v)));
         check($sformatf("rnd_ovf_%0d", v), 32'(ovf), 32'(v >= 10000));
      end

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
